order_entry_panel: RTL and testbench
====================================

# order_entry_panel

Operator input front end for the order-matching design, the input-side counterpart of the HEX/LEDR display driver. It synchronizes and debounces the board pushbuttons and slide switches and turns a submit press into one buy or sell order. It presents that order to the matching engine over a valid/ready handshake. It also holds the last accepted buy and sell prices, which feed the display's `buy_price`/`sell_price` inputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz). Counter width is clog2(DEBOUNCE_CYCLES+1). Must be ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `CLOCK_50`  in  1  system clock; all state updates on its rising edge
- `resetn`  in  1  asynchronous active-low reset
- `KEY`  in  3  raw pushbuttons, active-low; KEY[1]=submit, KEY[2]=clear, KEY[0] unused by this block
- `SW`  in  10  raw switches; SW[7:0]=price, SW[8]=side (0 buy, 1 sell), SW[9]=halt request
- `order_ready`  in  1  matching engine accepts the order on a cycle where valid&ready
- `order_valid`  out  1  order pending
- `order_price`  out  8  price of pending order
- `order_side`  out  1  side of pending order
- `buy_price`  out  8  last accepted buy price
- `sell_price`  out  8  last accepted sell price
- `entry_count`  out  8  accepted orders, wraps at 255→0
- `halt_signal`  out  1  synchronized SW[9]
- `reject_pulse`  out  1  one-cycle pulse when a submit is refused
- `state`  out  2  FSM state: 00 IDLE, 01 SEND

## Operation
- **Synchronizers.** Each KEY and SW bit passes through a 2-flop synchronizer. KEY flops reset to 1; SW flops reset to 0. `halt_signal` is the SW[9] synchronizer output. Price and side are always read from synchronized SW.
- **Debounce, per KEY[1] and KEY[2].**
  - A counter increments while the synchronized level differs from the debounced level, and clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized level and the counter clears.
  - The debounced level resets to 1.
  - A press is a 1→0 transition of the debounced level. It produces a registered one-cycle pulse (`submit_p`, `clear_p`). Releases produce no pulse.
- **FSM, IDLE.**
  - On `submit_p`:
    - If `halt_signal`=1 or price=0: pulse `reject_pulse` and stay in IDLE.
    - Otherwise: capture `order_price`, `order_side` and go to SEND.
  - On `clear_p`: zero `buy_price` and `sell_price` and stay in IDLE. `entry_count` is untouched.
  - If `submit_p` and `clear_p` fall in the same cycle, clear wins and the submit is discarded with no reject.
- **FSM, SEND.**
  - `order_valid`=1. `order_price` and `order_side` are held stable.
  - On `order_ready`=1:
    - Transfer completes.
    - Side 0 loads `buy_price`; side 1 loads `sell_price`.
    - `entry_count` increments, modulo 256.
    - FSM returns to IDLE.
  - On `clear_p` with `order_ready`=0: drop the order and return to IDLE. Stored prices are unchanged.
  - `order_ready` with `clear_p` in the same cycle: the transfer completes and the clear is discarded.
  - `submit_p` in SEND is ignored, with no reject.
  - SW changes while in SEND do not affect the pending order.
- **Halt while pending.** Halt asserted during SEND does not withdraw the order. The engine gates on halt itself.

## Timing
- **Reset values.** All outputs 0 (`order_valid`=0, prices 0, count 0, `state`=00). Debounce counters are 0.
- **Press latency.**
  - Edge 1 is the first rising edge on which a KEY is sampled low; the key stays low thereafter.
  - Synchronizer output goes low at edge 2.
  - The debounced level falls at edge 2+DEBOUNCE_CYCLES.
  - The press pulse is high after edge 3+DEBOUNCE_CYCLES.
  - `order_valid` rises after edge 4+DEBOUNCE_CYCLES.
- **Bounce.** A bounce shorter than DEBOUNCE_CYCLES consecutive cycles produces no pulse.
- **Handshake.**
  - Transfer occurs on the edge where `order_valid`&`order_ready`.
  - `order_valid` is low the cycle after.
  - `buy_price`/`sell_price`/`entry_count` update on that same edge.
  - At most one order per two cycles.
- **Reset mid-operation.** Asserting `resetn` low immediately clears the FSM to IDLE and drops any pending order; `order_valid`=0 asynchronously.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Buy, ready held.** Reset, SW=0x012, KEY[1] low 20 cycles, `order_ready`=1 → `order_valid` high exactly 1 cycle at edge 8; `order_price`=0x12, `order_side`=0; `buy_price`=0x12, `entry_count`=1.
- **Sell, late ready.** SW=0x1A5, press submit, hold `order_ready`=0 for 10 cycles while changing SW to 0x033, then ready=1 → price stays 0xA5 throughout; `sell_price`=0xA5, `buy_price` unchanged.
- **Bounce.** KEY[1] toggles low 3 cycles/high 1 cycle repeatedly → no `order_valid`; then held low → exactly one order.
- **Reject.** SW[9]=1 with price 0x40, press submit → `reject_pulse` one cycle, no valid, count unchanged. Repeat with SW[9]=0, price 0 → reject.
- **Clear.** Clear during SEND with ready=0 → valid drops next cycle, prices kept. Clear in IDLE → `buy_price`=`sell_price`=0. Clear coincident with ready → transfer counted.
- **Wrap and reset.** 256 accepted orders → `entry_count` wraps to 0. Async reset during SEND → all outputs 0 before next edge.

Source files
------------

// File: rtl/order_entry_panel.sv
// Operator input front end: synchronizes and debounces the board keys and switches,
// turns a submit press into one buy/sell order on a valid/ready handshake, and keeps the last traded prices.
module order_entry_panel #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [2:0] KEY,
    input  logic [9:0] SW,
    input  logic       order_ready,
    output logic       order_valid,
    output logic [7:0] order_price,
    output logic       order_side,
    output logic [7:0] buy_price,
    output logic [7:0] sell_price,
    output logic [7:0] entry_count,
    output logic       halt_signal,
    output logic       reject_pulse,
    output logic [1:0] state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SEND = 2'b01
    } state_t;

    logic [2:0] key_meta_q, key_sync_q;
    logic [9:0] sw_meta_q, sw_sync_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_meta_q <= 3'b111;
            key_sync_q <= 3'b111;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            key_meta_q <= KEY;
            key_sync_q <= key_meta_q;
            sw_meta_q  <= SW;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // KEY[0] is synchronized for uniformity but has no function here.
    logic unused_key0;
    assign unused_key0 = key_sync_q[0];

    // press_p[0] = submit (KEY[1]), press_p[1] = clear (KEY[2])
    logic [1:0] press_p;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_debounce
            logic [CW-1:0] cnt_q, cnt_d;
            logic          db_q, db_d;
            logic          db_dly_q;
            logic          press_q, press_d;

            always_comb begin
                cnt_d   = '0;
                db_d    = db_q;
                press_d = db_dly_q & ~db_q;
                if (key_sync_q[gi+1] != db_q) begin
                    // The increment that would reach DEBOUNCE_CYCLES commits the new level instead.
                    if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        db_d = key_sync_q[gi+1];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge CLOCK_50 or negedge resetn) begin
                if (!resetn) begin
                    cnt_q    <= '0;
                    db_q     <= 1'b1;
                    db_dly_q <= 1'b1;
                    press_q  <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    db_q     <= db_d;
                    db_dly_q <= db_q;
                    press_q  <= press_d;
                end
            end

            assign press_p[gi] = press_q;
        end
    endgenerate

    logic submit_p, clear_p;
    assign submit_p = press_p[0];
    assign clear_p  = press_p[1];

    state_t     state_q, state_d;
    logic       valid_q, valid_d;
    logic [7:0] price_q, price_d;
    logic       side_q, side_d;
    logic [7:0] buy_q, buy_d;
    logic [7:0] sell_q, sell_d;
    logic [7:0] count_q, count_d;
    logic       reject_q, reject_d;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        price_d  = price_q;
        side_d   = side_q;
        buy_d    = buy_q;
        sell_d   = sell_q;
        count_d  = count_q;
        reject_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_p) begin
                    buy_d  = '0;
                    sell_d = '0;
                end else if (submit_p) begin
                    if (sw_sync_q[9] || (sw_sync_q[7:0] == 8'h00)) begin
                        reject_d = 1'b1;
                    end else begin
                        price_d = sw_sync_q[7:0];
                        side_d  = sw_sync_q[8];
                        state_d = S_SEND;
                        valid_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                // A completing transfer takes priority over a clear in the same cycle.
                if (order_ready) begin
                    if (side_q) begin
                        sell_d = price_q;
                    end else begin
                        buy_d = price_q;
                    end
                    count_d = count_q + 8'd1;
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (clear_p) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            price_q  <= '0;
            side_q   <= 1'b0;
            buy_q    <= '0;
            sell_q   <= '0;
            count_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            price_q  <= price_d;
            side_q   <= side_d;
            buy_q    <= buy_d;
            sell_q   <= sell_d;
            count_q  <= count_d;
            reject_q <= reject_d;
        end
    end

    assign order_valid  = valid_q;
    assign order_price  = price_q;
    assign order_side   = side_q;
    assign buy_price    = buy_q;
    assign sell_price   = sell_q;
    assign entry_count  = count_q;
    assign halt_signal  = sw_sync_q[9];
    assign reject_pulse = reject_q;
    assign state        = state_q;

endmodule

// File: tb/tb_order_entry_panel.sv
// Directed bench for order_entry_panel with DEBOUNCE_CYCLES=4: a vector table of
// submit scenarios plus hand-written sequences for bounce, clear, wrap and async reset.
module tb_order_entry_panel;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] KEY;
    logic [9:0] SW;
    logic       order_ready;
    logic       order_valid;
    logic [7:0] order_price;
    logic       order_side;
    logic [7:0] buy_price;
    logic [7:0] sell_price;
    logic [7:0] entry_count;
    logic       halt_signal;
    logic       reject_pulse;
    logic [1:0] state;

    always #5 clk = ~clk;

    order_entry_panel #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .KEY         (KEY),
        .SW          (SW),
        .order_ready (order_ready),
        .order_valid (order_valid),
        .order_price (order_price),
        .order_side  (order_side),
        .buy_price   (buy_price),
        .sell_price  (sell_price),
        .entry_count (entry_count),
        .halt_signal (halt_signal),
        .reject_pulse(reject_pulse),
        .state       (state)
    );

    typedef struct {
        logic [9:0] sw;
        int         ready_wait;
        logic       accept;
    } vec_t;

    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    logic [7:0] buy_m, sell_m, count_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_buy"}, 32'(buy_price), 32'(buy_m));
        chk({tag, "_sell"}, 32'(sell_price), 32'(sell_m));
        chk({tag, "_count"}, 32'(entry_count), 32'(count_m));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(order_valid), 0);
        chk({tag, "_price"}, 32'(order_price), 0);
        chk({tag, "_side"}, 32'(order_side), 0);
        chk({tag, "_buy"}, 32'(buy_price), 0);
        chk({tag, "_sell"}, 32'(sell_price), 0);
        chk({tag, "_count"}, 32'(entry_count), 0);
        chk({tag, "_reject"}, 32'(reject_pulse), 0);
        chk({tag, "_state"}, 32'(state), 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        SW          = v.sw;
        order_ready = (v.ready_wait == 0);
        tick(3);
        KEY[1] = 1'b0;
        tick(7);
        chk("vec_pre_valid", 32'(order_valid), 0);
        tick(1);
        if (v.accept) begin
            chk("vec_valid", 32'(order_valid), 1);
            chk("vec_price", 32'(order_price), 32'(v.sw[7:0]));
            chk("vec_side", 32'(order_side), 32'(v.sw[8]));
            chk("vec_no_reject", 32'(reject_pulse), 0);
            chk("vec_state_send", 32'(state), 1);
            for (int i = 0; i < v.ready_wait; i++) begin
                if (i == 3) SW = 10'h033;
                tick(1);
                chk("vec_hold_valid", 32'(order_valid), 1);
                chk("vec_hold_price", 32'(order_price), 32'(v.sw[7:0]));
                chk("vec_hold_side", 32'(order_side), 32'(v.sw[8]));
            end
            order_ready = 1'b1;
            tick(1);
            chk("vec_valid_drop", 32'(order_valid), 0);
            chk("vec_state_idle", 32'(state), 0);
            if (v.sw[8]) sell_m = v.sw[7:0];
            else         buy_m  = v.sw[7:0];
            count_m = count_m + 8'd1;
            check_regs("vec_xfer");
        end else begin
            chk("vec_reject", 32'(reject_pulse), 1);
            chk("vec_rej_no_valid", 32'(order_valid), 0);
            chk("vec_halt", 32'(halt_signal), 32'(v.sw[9]));
            tick(1);
            chk("vec_reject_1cyc", 32'(reject_pulse), 0);
            chk("vec_rej_no_valid2", 32'(order_valid), 0);
            check_regs("vec_rej");
        end
        $display("vector %0d: sw=0x%03h ready_wait=%0d accept=%0b count=%0d",
                 idx, v.sw, v.ready_wait, v.accept, entry_count);
        KEY[1]      = 1'b1;
        order_ready = 1'b0;
        tick(10);
    endtask

    task automatic quick_order();
        KEY[1] = 1'b0;
        tick(9);
        KEY[1] = 1'b1;
        tick(8);
        count_m = count_m + 8'd1;
        buy_m   = 8'h01;
    endtask

    int vcnt;
    int rcnt;

    initial begin
        vecs[0] = '{10'h012, 0, 1'b1};
        vecs[1] = '{10'h1A5, 10, 1'b1};
        vecs[2] = '{10'h240, 0, 1'b0};
        vecs[3] = '{10'h000, 0, 1'b0};
        vecs[4] = '{10'h1FF, 2, 1'b1};
        vecs[5] = '{10'h080, 1, 1'b1};

        buy_m = 0; sell_m = 0; count_m = 0;
        resetn = 1'b1; KEY = 3'b111; SW = '0; order_ready = 1'b0;
        #2 resetn = 1'b0;
        #1 check_all_zero("reset");
        tick(2);
        check_all_zero("reset_clk");
        resetn = 1'b1;
        tick(3);
        check_all_zero("after_reset");
        $display("reset: state=%0d valid=%0b count=%0d", state, order_valid, entry_count);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Bounce: 3 low / 1 high never reaches 4 stable cycles.
        SW = 10'h055; order_ready = 1'b1;
        tick(3);
        vcnt = 0; rcnt = 0;
        for (int r = 0; r < 5; r++) begin
            KEY[1] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick(1);
                if (order_valid) vcnt++;
                if (reject_pulse) rcnt++;
            end
            KEY[1] = 1'b1;
            tick(1);
            if (order_valid) vcnt++;
            if (reject_pulse) rcnt++;
        end
        for (int k = 0; k < 4; k++) begin
            tick(1);
            if (order_valid) vcnt++;
        end
        chk("bounce_no_valid", vcnt, 0);
        KEY[1] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (order_valid) vcnt++;
            if (reject_pulse) rcnt++;
        end
        chk("bounce_one_order", vcnt, 1);
        chk("bounce_no_reject", rcnt, 0);
        buy_m = 8'h55; count_m = count_m + 8'd1;
        check_regs("bounce");
        $display("bounce: valid_cycles=%0d count=%0d", vcnt, entry_count);
        KEY[1] = 1'b1; order_ready = 1'b0;
        tick(10);

        // Clear during SEND, ready low: order dropped, prices kept.
        SW = 10'h077;
        tick(3);
        KEY[1] = 1'b0;
        tick(8);
        chk("clrsend_valid", 32'(order_valid), 1);
        KEY[2] = 1'b0;
        tick(7);
        chk("clrsend_valid_pre", 32'(order_valid), 1);
        tick(1);
        chk("clrsend_valid_drop", 32'(order_valid), 0);
        chk("clrsend_state", 32'(state), 0);
        check_regs("clrsend");
        $display("clear in SEND: valid=%0b buy=0x%02h sell=0x%02h", order_valid, buy_price, sell_price);
        KEY = 3'b111;
        tick(10);
        chk("clrsend_stay_idle", 32'(order_valid), 0);

        // Clear in IDLE zeroes both prices, count untouched.
        KEY[2] = 1'b0;
        tick(8);
        buy_m = 0; sell_m = 0;
        check_regs("clridle");
        $display("clear in IDLE: buy=0x%02h sell=0x%02h count=%0d", buy_price, sell_price, entry_count);
        KEY[2] = 1'b1;
        tick(10);

        // Clear coincident with ready: transfer completes, clear discarded.
        SW = 10'h0C3;
        tick(3);
        KEY[1] = 1'b0;
        tick(8);
        chk("clrrdy_valid", 32'(order_valid), 1);
        KEY[2] = 1'b0;
        tick(7);
        order_ready = 1'b1;
        tick(1);
        chk("clrrdy_valid_drop", 32'(order_valid), 0);
        buy_m = 8'hC3; count_m = count_m + 8'd1;
        check_regs("clrrdy");
        tick(1);
        check_regs("clrrdy_after");
        $display("clear with ready: buy=0x%02h count=%0d", buy_price, entry_count);
        KEY = 3'b111; order_ready = 1'b0;
        tick(10);

        // Submit and clear together in IDLE: clear wins, no reject even with halt set.
        SW = 10'h211;
        tick(3);
        KEY[2:1] = 2'b00;
        vcnt = 0; rcnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (order_valid) vcnt++;
            if (reject_pulse) rcnt++;
        end
        chk("both_no_valid", vcnt, 0);
        chk("both_no_reject", rcnt, 0);
        buy_m = 0; sell_m = 0;
        check_regs("both");
        $display("submit+clear: valid_cycles=%0d rejects=%0d buy=0x%02h", vcnt, rcnt, buy_price);
        KEY = 3'b111;
        tick(10);

        // Count wrap.
        SW = 10'h001; order_ready = 1'b1;
        tick(3);
        while (count_m != 8'hFF) quick_order();
        check_regs("wrap_255");
        quick_order();
        chk("wrap_zero", 32'(entry_count), 0);
        check_regs("wrap");
        $display("wrap: count=%0d buy=0x%02h", entry_count, buy_price);
        order_ready = 1'b0;

        // Async reset during SEND.
        SW = 10'h1B2;
        tick(3);
        KEY[1] = 1'b0;
        tick(8);
        chk("arst_valid_before", 32'(order_valid), 1);
        #2 resetn = 1'b0;
        KEY = 3'b111;
        #1 check_all_zero("arst");
        $display("async reset: valid=%0b state=%0d count=%0d", order_valid, state, entry_count);
        tick(2);
        resetn = 1'b1;
        tick(3);
        chk("arst_post_valid", 32'(order_valid), 0);
        chk("arst_post_state", 32'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
